// File: rtl/order_translate_nch.sv
// Order-to-address translator: per channel, bank = digit sum mod RADIX and
// ma = order >> DIGIT_W, through an NDIG-deep valid/ready pipeline with flush.
module order_translate_nch #(
    parameter int NCH     = 2,
    parameter int D_WIDTH = 16,
    parameter int DIGIT_W = 4,
    parameter int L_W     = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NCH*D_WIDTH-1:0]             in_order,
    input  logic                               in_done,
    input  logic [L_W-1:0]                     in_l,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NCH*DIGIT_W-1:0]             out_bank,
    output logic [NCH*(D_WIDTH-DIGIT_W)-1:0]   out_ma,
    output logic                               out_conflict,
    output logic                               out_done,
    output logic [L_W-1:0]                     out_l
);

    localparam int unsigned NDIG = D_WIDTH / DIGIT_W;
    localparam int unsigned NST  = NDIG - 1;
    localparam int unsigned MA_W = D_WIDTH - DIGIT_W;

    // Stages S0..S(NST-1); the output register is the final stage.
    logic [NST-1:0]     r_vld;
    logic [D_WIDTH-1:0] r_ord  [NST][NCH];
    logic [DIGIT_W-1:0] r_sum  [NST][NCH];
    logic [NST-1:0]     r_done;
    logic [L_W-1:0]     r_l    [NST];

    logic                   r_out_valid;
    logic [NCH*DIGIT_W-1:0] r_out_bank;
    logic [NCH*MA_W-1:0]    r_out_ma;
    logic                   r_out_conflict;
    logic                   r_out_done;
    logic [L_W-1:0]         r_out_l;

    logic                   w_stall;
    logic                   w_adv;
    logic [NST-1:0]         w_v;
    logic                   w_ov;
    logic [DIGIT_W-1:0]     w_bank [NCH];
    logic                   w_conflict;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;
    // Flush forces an advance so every valid bit is cleared even while stalled.
    assign w_adv    = flush || !w_stall;

    always_comb begin
        w_v    = '0;
        w_v[0] = in_valid && !flush;
        for (int unsigned s = 1; s < NST; s++) begin
            w_v[s] = r_vld[s-1] && !flush;
        end
        w_ov = r_vld[NST-1] && !flush;
    end

    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            w_bank[c] = r_sum[NST-1][c] + r_ord[NST-1][c][D_WIDTH-1 -: DIGIT_W];
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            for (int unsigned d = c + 1; d < NCH; d++) begin
                if (w_bank[c] == w_bank[d]) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld          <= '0;
            r_done         <= '0;
            for (int unsigned s = 0; s < NST; s++) begin
                r_l[s] <= '0;
                for (int unsigned c = 0; c < NCH; c++) begin
                    r_ord[s][c] <= '0;
                    r_sum[s][c] <= '0;
                end
            end
            r_out_valid    <= 1'b0;
            r_out_bank     <= '0;
            r_out_ma       <= '0;
            r_out_conflict <= 1'b0;
            r_out_done     <= 1'b0;
            r_out_l        <= '0;
        end else if (w_adv) begin
            r_vld     <= w_v;
            r_done[0] <= w_v[0] && in_done;
            r_l[0]    <= w_v[0] ? in_l : '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                r_ord[0][c] <= w_v[0] ? in_order[c*D_WIDTH +: D_WIDTH] : '0;
                r_sum[0][c] <= w_v[0] ? in_order[c*D_WIDTH +: DIGIT_W] : '0;
            end
            // Stage s adds digit s to the running sum carried from stage s-1.
            for (int unsigned s = 1; s < NST; s++) begin
                r_done[s] <= w_v[s] && r_done[s-1];
                r_l[s]    <= w_v[s] ? r_l[s-1] : '0;
                for (int unsigned c = 0; c < NCH; c++) begin
                    r_ord[s][c] <= w_v[s] ? r_ord[s-1][c] : '0;
                    r_sum[s][c] <= w_v[s] ?
                        DIGIT_W'(r_sum[s-1][c] + r_ord[s-1][c][s*DIGIT_W +: DIGIT_W]) : '0;
                end
            end
            r_out_valid    <= w_ov;
            r_out_conflict <= w_ov && w_conflict;
            r_out_done     <= w_ov && r_done[NST-1];
            r_out_l        <= w_ov ? r_l[NST-1] : '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                r_out_bank[c*DIGIT_W +: DIGIT_W] <= w_ov ? w_bank[c] : '0;
                r_out_ma[c*MA_W +: MA_W]         <= w_ov ? r_ord[NST-1][c][D_WIDTH-1:DIGIT_W] : '0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_bank     = r_out_bank;
    assign out_ma       = r_out_ma;
    assign out_conflict = r_out_conflict;
    assign out_done     = r_out_done;
    assign out_l        = r_out_l;

endmodule

// File: tb/tb_order_translate_nch.sv
// Directed bench for order_translate_nch with default parameters (NCH=2, 16-bit orders, 4-bit digits).
module tb_order_translate_nch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_order;
    logic        in_done;
    logic [2:0]  in_l;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_bank;
    logic [23:0] out_ma;
    logic        out_conflict;
    logic        out_done;
    logic [2:0]  out_l;

    int errors = 0;
    int checks = 0;

    order_translate_nch #(.NCH(2), .D_WIDTH(16), .DIGIT_W(4), .L_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_order(in_order),
        .in_done(in_done), .in_l(in_l),
        .out_valid(out_valid), .out_ready(out_ready), .out_bank(out_bank),
        .out_ma(out_ma), .out_conflict(out_conflict), .out_done(out_done), .out_l(out_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] o0, o1;
        logic [2:0]  l;
        logic        done;
        logic [3:0]  b0, b1;
        logic [11:0] m0, m1;
        logic        conf;
    } vec_t;

    typedef struct {
        logic [31:0] ord;
        logic        done;
        logic [2:0]  l;
    } beat_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] mbank(input logic [15:0] o);
        logic [3:0] s;
        s = 4'h0;
        for (int k = 0; k < 4; k++) s = s + o[k*4 +: 4];
        return s;
    endfunction

    task automatic cmp_out(input beat_t b, input string tag);
        logic [3:0] b0, b1;
        b0 = mbank(b.ord[15:0]);
        b1 = mbank(b.ord[31:16]);
        chk({tag, "_bank"}, 64'(out_bank), 64'({b1, b0}));
        chk({tag, "_ma"}, 64'(out_ma), 64'({b.ord[31:20], b.ord[15:4]}));
        chk({tag, "_conflict"}, 64'(out_conflict), 64'(b0 == b1));
        chk({tag, "_done"}, 64'(out_done), 64'(b.done));
        chk({tag, "_l"}, 64'(out_l), 64'(b.l));
    endtask

    // Called at posedge+1 with the pipeline empty and out_ready high.
    task automatic send_expect(input string tag, input vec_t v);
        int n;
        in_valid = 1'b1;
        in_order = {v.o1, v.o0};
        in_l     = v.l;
        in_done  = v.done;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_order = '0;
        in_l     = '0;
        in_done  = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd3);
        chk({tag, "_bank"}, 64'(out_bank), 64'({v.b1, v.b0}));
        chk({tag, "_ma"}, 64'(out_ma), 64'({v.m1, v.m0}));
        chk({tag, "_conflict"}, 64'(out_conflict), 64'(v.conf));
        chk({tag, "_done"}, 64'(out_done), 64'(v.done));
        chk({tag, "_l"}, 64'(out_l), 64'(v.l));
        @(posedge clk); #1;
        chk({tag, "_one_cycle"}, 64'(out_valid), 64'd0);
        chk({tag, "_zero_bank"}, 64'(out_bank), 64'd0);
    endtask

    // Streams n random beats; out_ready is low for cycles [st_start, st_start+st_len).
    task automatic run_stream(input string tag, input int n, input int st_start, input int st_len);
        beat_t q[$];
        beat_t cur, b;
        bit    have_cur, started, prev_stall;
        int    sent, got, cyc, bubbles;
        logic [7:0]  snap_bank;
        logic [23:0] snap_ma;
        sent = 0; got = 0; cyc = 0; bubbles = 0;
        have_cur = 0; started = 0; prev_stall = 0;
        snap_bank = '0; snap_ma = '0;
        while (got < n && cyc < n + 60) begin
            out_ready = !(cyc >= st_start && cyc < st_start + st_len);
            #1;
            if (prev_stall) begin
                chk({tag, "_stall_bank_stable"}, 64'(out_bank), 64'(snap_bank));
                chk({tag, "_stall_ma_stable"}, 64'(out_ma), 64'(snap_ma));
            end
            chk({tag, "_in_ready"}, 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid) begin
                started = 1;
                if (out_ready) begin
                    if (q.size() == 0) begin
                        chk({tag, "_unexpected_beat"}, 64'd1, 64'd0);
                    end else begin
                        b = q.pop_front();
                        cmp_out(b, tag);
                    end
                    got++;
                end
            end else if (started && got < n) begin
                bubbles++;
            end
            prev_stall = out_valid && !out_ready;
            snap_bank  = out_bank;
            snap_ma    = out_ma;
            if (sent < n) begin
                if (!have_cur) begin
                    cur.ord  = $urandom;
                    cur.l    = 3'($urandom_range(0, 7));
                    cur.done = (sent == n - 1);
                    have_cur = 1;
                end
                in_valid = 1'b1;
                in_order = cur.ord;
                in_l     = cur.l;
                in_done  = cur.done;
                if (in_ready) begin
                    q.push_back(cur);
                    sent++;
                    have_cur = 0;
                end
            end else begin
                in_valid = 1'b0;
                in_order = '0;
                in_l     = '0;
                in_done  = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        chk({tag, "_count"}, 64'(got), 64'(n));
        chk({tag, "_bubbles"}, 64'(bubbles), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        vt[0] = '{16'h1234, 16'h00F1, 3'd5, 1'b0, 4'hA, 4'h0, 12'h123, 12'h00F, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0000, 3'd1, 1'b0, 4'hC, 4'h0, 12'hFFF, 12'h000, 1'b0};
        vt[2] = '{16'h1234, 16'h4321, 3'd2, 1'b0, 4'hA, 4'hA, 12'h123, 12'h432, 1'b1};
        vt[3] = '{16'h0000, 16'h0000, 3'd0, 1'b0, 4'h0, 4'h0, 12'h000, 12'h000, 1'b1};
        vt[4] = '{16'h0F0F, 16'h1111, 3'd7, 1'b1, 4'hE, 4'h4, 12'h0F0, 12'h111, 1'b0};
        vt[5] = '{16'h8888, 16'h7777, 3'd3, 1'b0, 4'h0, 4'hC, 12'h888, 12'h777, 1'b0};
        vt[6] = '{16'hABCD, 16'h0004, 3'd4, 1'b1, 4'hE, 4'h4, 12'hABC, 12'h000, 1'b0};
        vt[7] = '{16'h0010, 16'h0001, 3'd6, 1'b0, 4'h1, 4'h1, 12'h001, 12'h000, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_order = '0;
        in_done = 1'b0; in_l = '0; out_ready = 1'b1;
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_bank", 64'(out_bank), 64'd0);
        chk("reset_out_ma", 64'(out_ma), 64'd0);
        chk("reset_out_conflict", 64'(out_conflict), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            send_expect($sformatf("vec%0d", i), vt[i]);
        end

        run_stream("stream", 64, 1000, 0);
        repeat (4) @(posedge clk);
        #1;
        run_stream("backpressure", 24, 10, 3);
        repeat (4) @(posedge clk);
        #1;

        // Flush: three beats in flight, flush with a fourth beat presented alongside.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_order = {16'h1111 * 16'(k + 1), 16'h0F0F};
            in_l = 3'd2; in_done = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        in_order = 32'hAAAA5555;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; in_order = '0; in_l = '0; in_done = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) seen = 1;
            @(posedge clk); #1;
        end
        chk("flush_no_output", 64'(seen), 64'd0);
        send_expect("after_flush", vt[2]);

        // Reset with beats in flight and one already presented at the output.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_order = {16'h1234, 16'h4321};
            in_l = 3'd6; in_done = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_order = '0; in_l = '0; in_done = 1'b0;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_out_bank", 64'(out_bank), 64'd0);
        chk("midreset_out_ma", 64'(out_ma), 64'd0);
        chk("midreset_out_conflict", 64'(out_conflict), 64'd0);
        chk("midreset_out_done", 64'(out_done), 64'd0);
        chk("midreset_out_l", 64'(out_l), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("postreset_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) seen = 1;
            @(posedge clk); #1;
        end
        chk("postreset_no_stale", 64'(seen), 64'd0);
        send_expect("after_reset", vt[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
